control_unit: RTL and testbench

//  Upstream controller for DataPath: owns PC, IR and the instruction FSM. Fetches 16-bit

---
 rtl/control_unit.sv | 139 +++++++++++++
 tb/tb_control_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: instruction sequencer for the DataPath.
// Owns the program counter, the instruction register and the instruction FSM.
// It fetches 16-bit words from a registered instruction ROM and drives every
// DataPath control input as a Moore function of state and IR.
module control_unit #(
    parameter int          PC_W    = 7,
    parameter logic [2:0]  ALU_ADD = 3'd1,
    parameter logic [2:0]  ALU_SUB = 3'd2
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic [15:0]     I_data,
    output logic [PC_W-1:0] I_addr,
    output logic [7:0]      D_Addr,
    output logic            D_wr,
    output logic            RF_s,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_en,
    output logic [3:0]      RF_Ra_addr,
    output logic [3:0]      RF_Rb_addr,
    output logic [2:0]      Alu_s0,
    output logic [3:0]      State,
    output logic            Halted
);

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8,
        S_NOOP   = 4'd9
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    // State, PC and IR registers; reset returns to INIT with PC and IR cleared
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state logic; DECODE dispatches on the ROM word directly because IR
    // only captures that word at the end of the DECODE cycle
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_INIT: begin
                pc_d    = '0;
                ir_d    = '0;
                state_d = S_FETCH;
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d = I_data;
                pc_d = pc_q + PC_W'(1);
                case (I_data[15:12])
                    4'h1:    state_d = S_STORE;
                    4'h2:    state_d = S_LOAD_A;
                    4'h3:    state_d = S_ADD;
                    4'h4:    state_d = S_SUB;
                    4'h5:    state_d = S_HALT;
                    default: state_d = S_NOOP;   // NOOP and all illegal opcodes
                endcase
            end
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B,
            S_STORE,
            S_ADD,
            S_SUB,
            S_NOOP:   state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_INIT;
        endcase
    end

    assign I_addr = pc_q;
    assign State  = state_q;

    // Moore control outputs; write enables are masked while Reset is high so
    // no DataPath write slips out in the reset cycle
    always_comb begin
        D_Addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 1'b0;
        RF_W_addr  = '0;
        RF_W_en    = 1'b0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        Alu_s0     = '0;
        Halted     = 1'b0;
        case (state_q)
            S_LOAD_A: begin
                D_Addr = ir_q[11:4];
                RF_s   = 1'b1;
            end
            S_LOAD_B: begin
                D_Addr    = ir_q[11:4];
                RF_s      = 1'b1;
                RF_W_addr = ir_q[3:0];
                RF_W_en   = 1'b1;
            end
            S_STORE: begin
                RF_Ra_addr = ir_q[11:8];
                D_Addr     = ir_q[7:0];
                D_wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                RF_Ra_addr = ir_q[11:8];
                RF_Rb_addr = ir_q[7:4];
                RF_W_addr  = ir_q[3:0];
                RF_W_en    = 1'b1;
                Alu_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT:  Halted = 1'b1;
            default: ;
        endcase
        if (Reset) begin
            D_wr    = 1'b0;
            RF_W_en = 1'b0;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: drives control_unit from a registered ROM model and checks
// every cycle against an instruction-level trace predicted from the ISA rules.
module tb_control_unit;

    localparam int PC_W  = 7;
    localparam int DEPTH = 2 ** PC_W;

    logic            Clk;
    logic            Reset;
    logic [15:0]     I_data;
    logic [PC_W-1:0] I_addr;
    logic [7:0]      D_Addr;
    logic            D_wr;
    logic            RF_s;
    logic [3:0]      RF_W_addr;
    logic            RF_W_en;
    logic [3:0]      RF_Ra_addr;
    logic [3:0]      RF_Rb_addr;
    logic [2:0]      Alu_s0;
    logic [3:0]      State;
    logic            Halted;

    int total = 0;
    int bad   = 0;

    logic [15:0] rom [DEPTH];
    logic [37:0] exp_q [$];
    logic [37:0] dut_vec;

    control_unit #(.PC_W(PC_W), .ALU_ADD(3'd1), .ALU_SUB(3'd2)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .I_data     (I_data),
        .I_addr     (I_addr),
        .D_Addr     (D_Addr),
        .D_wr       (D_wr),
        .RF_s       (RF_s),
        .RF_W_addr  (RF_W_addr),
        .RF_W_en    (RF_W_en),
        .RF_Ra_addr (RF_Ra_addr),
        .RF_Rb_addr (RF_Rb_addr),
        .Alu_s0     (Alu_s0),
        .State      (State),
        .Halted     (Halted)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Registered instruction ROM: data appears one cycle after the address
    always @(posedge Clk) I_data <= rom[I_addr];

    assign dut_vec = {State, Halted, I_addr, D_Addr, D_wr, RF_s, RF_W_addr,
                      RF_W_en, RF_Ra_addr, RF_Rb_addr, Alu_s0};

    function automatic logic [37:0] mk(input int st, input int hlt, input int ia,
                                       input int da, input int dw, input int rs,
                                       input int wa, input int we, input int ra,
                                       input int rb, input int alu);
        return {4'(st), 1'(hlt), 7'(ia), 8'(da), 1'(dw), 1'(rs), 4'(wa),
                1'(we), 4'(ra), 4'(rb), 3'(alu)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Instruction-level reference: walks the program from PC 0 and emits the
    // expected output vector for each clock cycle after reset release
    task automatic build_trace(input int n);
        int pc, npc;
        logic [15:0] ir;
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        pc = 0;
        while (exp_q.size() < n) begin
            ir  = rom[pc];
            npc = (pc + 1) % DEPTH;
            exp_q.push_back(mk(1, 0, pc, 0, 0, 0, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(2, 0, pc, 0, 0, 0, 0, 0, 0, 0, 0));
            case (ir[15:12])
                4'h1: exp_q.push_back(mk(5, 0, npc, ir[7:0], 1, 0, 0, 0, ir[11:8], 0, 0));
                4'h2: begin
                    exp_q.push_back(mk(3, 0, npc, ir[11:4], 0, 1, 0, 0, 0, 0, 0));
                    exp_q.push_back(mk(4, 0, npc, ir[11:4], 0, 1, ir[3:0], 1, 0, 0, 0));
                end
                4'h3: exp_q.push_back(mk(6, 0, npc, 0, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 1));
                4'h4: exp_q.push_back(mk(7, 0, npc, 0, 0, 0, ir[3:0], 1, ir[11:8], ir[7:4], 2));
                4'h5: while (exp_q.size() < n)
                          exp_q.push_back(mk(8, 1, npc, 0, 0, 0, 0, 0, 0, 0, 0));
                default: exp_q.push_back(mk(9, 0, npc, 0, 0, 0, 0, 0, 0, 0, 0));
            endcase
            pc = npc;
        end
    endtask

    // Two reset cycles, then release on a falling edge; the DUT sits in INIT
    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic run_trace(input int n, input string name);
        build_trace(n);
        do_reset();
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge Clk);
            #1;
            check($sformatf("%s cyc%0d", name, i), dut_vec, exp_q[i]);
        end
        $display("trace %s: %0d cycles compared, bad so far=%0d", name, n, bad);
    endtask

    task automatic wait_state(input logic [3:0] s);
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            #1;
            if (State === s) break;
        end
    endtask

    task automatic random_rom(input bit allow_halt);
        logic [15:0] w;
        for (int a = 0; a < DEPTH; a++) begin
            w = 16'($urandom);
            if (!allow_halt && w[15:12] == 4'h5) w[15:12] = 4'h0;
            if (allow_halt && w[15:12] == 4'h5 && $urandom_range(0, 3) != 0) w[15:12] = 4'h3;
            rom[a] = w;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        for (int a = 0; a < DEPTH; a++) rom[a] = 16'h0000;

        // Reset state, sampled while Reset is still high
        repeat (2) @(posedge Clk);
        #1;
        check("reset State", State, 0);
        check("reset I_addr", I_addr, 0);
        check("reset enables", {D_wr, RF_W_en, Halted}, 0);
        $display("step reset: State=%0d I_addr=%0d", State, I_addr);

        // Directed program: loads, add, sub, store, illegal, noop, halt
        rom[0] = 16'h2053; rom[1] = 16'h2001; rom[2] = 16'h2012;
        rom[3] = 16'h3124; rom[4] = 16'h4215; rom[5] = 16'h1409;
        rom[6] = 16'hF123; rom[7] = 16'h0000; rom[8] = 16'h5000;
        run_trace(1 + 4*3 + 3*2 + 3 + 3*2 + 2 + 25, "directed");
        check("halt Halted", Halted, 1);
        check("halt State", State, 8);
        check("halt I_addr", I_addr, 9);

        // Reset dominates HALT
        Reset = 1'b1;
        @(negedge Clk); #1;
        check("halt reset State", State, 0);
        check("halt reset I_addr", I_addr, 0);
        check("halt reset Halted", Halted, 0);
        Reset = 1'b0;
        $display("step halt reset: State=%0d Halted=%0d", State, Halted);

        // Reset landing in LOAD_B, then in STORE: writes must be masked
        for (int a = 0; a < DEPTH; a++) rom[a] = 16'h0000;
        rom[0] = 16'h2053; rom[1] = 16'h1409;
        do_reset();
        wait_state(4'd4);
        check("reach LOAD_B", State, 4);
        check("LOAD_B wen", RF_W_en, 1);
        Reset = 1'b1; #1;
        check("LOAD_B reset wen", RF_W_en, 0);
        @(negedge Clk); #1;
        check("LOAD_B reset State", State, 0);
        check("LOAD_B reset I_addr", I_addr, 0);
        Reset = 1'b0;
        wait_state(4'd5);
        check("reach STORE", State, 5);
        check("STORE dwr", D_wr, 1);
        Reset = 1'b1; #1;
        check("STORE reset dwr", D_wr, 0);
        @(negedge Clk); #1;
        check("STORE reset State", State, 0);
        Reset = 1'b0;
        $display("step mid-instruction resets: State=%0d", State);

        // Random programs; without HALT the PC wraps past 127 back to 0
        random_rom(1'b0);
        run_trace(700, "random_nohalt");
        random_rom(1'b1);
        run_trace(500, "random_halt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
